// File: rtl/sos_coef_loader.sv
// sos_coef_loader: framed SOS coefficient loader with stability check and idle-gated atomic commit
module sos_coef_loader #(
    parameter int NUM_SEC = 4,
    parameter int COEF_W  = 24
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [COEF_W-1:0]         cfg_data,
    input  logic                      cfg_last,
    input  logic                      filt_idle,
    output logic [NUM_SEC*COEF_W-1:0] b0_bus,
    output logic [NUM_SEC*COEF_W-1:0] b1_bus,
    output logic [NUM_SEC*COEF_W-1:0] b2_bus,
    output logic [NUM_SEC*COEF_W-1:0] a1_bus,
    output logic [NUM_SEC*COEF_W-1:0] a2_bus,
    output logic                      commit_done,
    output logic                      err_len,
    output logic                      err_unstable,
    output logic [3:0]                err_sec,
    output logic [7:0]                cfg_gen
);
    localparam int N  = 5 * NUM_SEC;
    localparam int WW = $clog2(N);
    localparam logic [COEF_W-1:0] UNITY = COEF_W'(1 << (COEF_W - 2));
    localparam logic signed [COEF_W+1:0] ONE = {2'b00, UNITY};

    typedef enum logic [2:0] {LOAD, FLUSH, CHECK, WAIT, COMMIT} state_t;

    state_t                    state, state_nx;
    logic [WW-1:0]             wcnt;
    logic [3:0]                csec;
    logic [N*COEF_W-1:0]       shadow;
    logic                      xfer, last_word, len_err, sec_bad;
    logic [COEF_W-1:0]         a1_w, a2_w;
    logic signed [COEF_W+1:0]  a1_x, a2_x, a1_abs;

    assign cfg_ready   = rst_n && (state == LOAD || state == FLUSH || state == COMMIT);
    assign xfer        = cfg_valid && cfg_ready;
    assign last_word   = wcnt == WW'(N - 1);
    assign commit_done = state == COMMIT;

    // Denominator 1 + a1 z^-1 + a2 z^-2 of the section under test, widened so |a1| and 1+a2 cannot overflow
    assign a1_w   = shadow[(5 * csec + 3) * COEF_W +: COEF_W];
    assign a2_w   = shadow[(5 * csec + 4) * COEF_W +: COEF_W];
    assign a1_x   = {{2{a1_w[COEF_W-1]}}, a1_w};
    assign a2_x   = {{2{a2_w[COEF_W-1]}}, a2_w};
    assign a1_abs = a1_x[COEF_W+1] ? -a1_x : a1_x;
    assign sec_bad = !((a2_x > -ONE) && (a2_x < ONE) && (a1_abs < ONE + a2_x));

    // Next-state and length-error detection
    always_comb begin
        state_nx = state;
        len_err  = 1'b0;
        case (state)
            LOAD, COMMIT: begin
                state_nx = (xfer && last_word) ? (cfg_last ? CHECK : FLUSH) : LOAD;
                len_err  = xfer && (last_word != cfg_last);
            end
            FLUSH:   state_nx = (xfer && cfg_last) ? LOAD : FLUSH;
            CHECK:   state_nx = sec_bad ? LOAD : (csec == 4'(NUM_SEC - 1)) ? WAIT : CHECK;
            WAIT:    state_nx = filt_idle ? COMMIT : WAIT;
            default: state_nx = LOAD;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LOAD;
        else        state <= state_nx;
    end

    // Shadow fill, section scan, error pulses and the atomic bank swap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt         <= '0;
            csec         <= '0;
            shadow       <= '0;
            err_len      <= 1'b0;
            err_unstable <= 1'b0;
            err_sec      <= '0;
            cfg_gen      <= '0;
            b0_bus       <= {NUM_SEC{UNITY}};
            b1_bus       <= '0;
            b2_bus       <= '0;
            a1_bus       <= '0;
            a2_bus       <= '0;
        end else begin
            err_len      <= len_err;
            err_unstable <= (state == CHECK) && sec_bad;
            csec         <= (state == CHECK) ? csec + 4'd1 : 4'd0;
            if ((state == CHECK) && sec_bad) err_sec <= csec;
            if (xfer && (state == LOAD || state == COMMIT)) begin
                shadow[wcnt * COEF_W +: COEF_W] <= cfg_data;
                wcnt <= (last_word || cfg_last) ? '0 : wcnt + 1'b1;
            end
            if (state == WAIT && filt_idle) begin
                cfg_gen <= cfg_gen + 8'd1;
                for (int k = 0; k < NUM_SEC; k++) begin
                    b0_bus[k * COEF_W +: COEF_W] <= shadow[(5 * k + 0) * COEF_W +: COEF_W];
                    b1_bus[k * COEF_W +: COEF_W] <= shadow[(5 * k + 1) * COEF_W +: COEF_W];
                    b2_bus[k * COEF_W +: COEF_W] <= shadow[(5 * k + 2) * COEF_W +: COEF_W];
                    a1_bus[k * COEF_W +: COEF_W] <= shadow[(5 * k + 3) * COEF_W +: COEF_W];
                    a2_bus[k * COEF_W +: COEF_W] <= shadow[(5 * k + 4) * COEF_W +: COEF_W];
                end
            end
        end
    end
endmodule

// File: tb/tb_sos_coef_loader.sv
// tb_sos_coef_loader: randomized frames against a scoreboard of expected commits and errors
module tb_sos_coef_loader;
    localparam int NS  = 4;
    localparam int W   = 24;
    localparam int N   = 5 * NS;
    localparam int BW  = NS * W;
    localparam int P   = 10;
    localparam int ONE = 4194304;

    logic          clk = 1'b0, rst_n = 1'b0, cfg_valid = 1'b0, cfg_last = 1'b0, filt_idle = 1'b1;
    logic [W-1:0]  cfg_data = '0;
    logic          cfg_ready, commit_done, err_len, err_unstable;
    logic [BW-1:0] b0_bus, b1_bus, b2_bus, a1_bus, a2_bus;
    logic [3:0]    err_sec;
    logic [7:0]    cfg_gen;

    sos_coef_loader #(.NUM_SEC(NS), .COEF_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_data(cfg_data), .cfg_last(cfg_last), .filt_idle(filt_idle),
        .b0_bus(b0_bus), .b1_bus(b1_bus), .b2_bus(b2_bus), .a1_bus(a1_bus), .a2_bus(a2_bus),
        .commit_done(commit_done), .err_len(err_len), .err_unstable(err_unstable),
        .err_sec(err_sec), .cfg_gen(cfg_gen)
    );

    always #(P / 2) clk = ~clk;

    // kind: 0 commit, 1 length error, 2 unstable section
    typedef struct {
        int                   kind;
        int                   sec;
        bit                   lat;
        logic [4:0][BW-1:0]   bank;
    } exp_t;

    exp_t               sb[$];
    int                 frm[$];
    logic [4:0][BW-1:0] exp_act, pass_bank;
    int                 exp_gen = 0, exp_sec = 0, n_tests = 0, n_fail = 0;
    time                t_last = 0;
    bit                 lat_mode = 1'b1;

    task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", nm, got, exp, $time);
        end
    endtask

    function automatic int sx(input int v);
        logic [W-1:0] t;
        t = v[W-1:0];
        return $signed(t);
    endfunction

    // Reference model: classify a frame by length and the stability triangle, and build its bank
    task automatic expect_frame();
        exp_t e;
        int a1, a2, w;
        e.kind = (frm.size() == N) ? 0 : 1;
        e.sec  = 0;
        e.lat  = lat_mode;
        e.bank = '0;
        if (e.kind == 0) begin
            for (int k = 0; k < NS; k++) begin
                a1 = sx(frm[5 * k + 3]);
                a2 = sx(frm[5 * k + 4]);
                if (e.kind == 0 && !(a2 > -ONE && a2 < ONE && (a1 < 0 ? -a1 : a1) < ONE + a2)) begin
                    e.kind = 2;
                    e.sec  = k;
                end
                for (int j = 0; j < 5; j++) begin
                    w = frm[5 * k + j];
                    e.bank[j][k * W +: W] = w[W-1:0];
                end
            end
        end
        sb.push_back(e);
    endtask

    // mode 0 stable, 1 fully random denominator, 2 boundary of the triangle
    task automatic add_sec(input int mode);
        int a1, a2, lim, sel;
        frm.push_back(int'($urandom));
        frm.push_back(int'($urandom));
        frm.push_back(int'($urandom));
        a2 = int'($urandom_range(0, 8388606)) - 4194303;
        lim = 4194303 + a2;
        a1 = int'($urandom_range(0, 2 * lim)) - lim;
        if (mode == 1) begin
            a1 = int'($urandom);
            a2 = int'($urandom);
        end else if (mode == 2) begin
            sel = int'($urandom_range(0, 5));
            if (sel == 0) begin a2 = ONE;      a1 = 0; end
            if (sel == 1) begin a2 = -ONE;     a1 = 0; end
            if (sel == 2) a1 = ONE + a2;
            if (sel == 3) a1 = -(ONE + a2);
            if (sel == 4) begin a2 = ONE - 1;  a1 = -8388606; end
            if (sel == 5) begin a2 = ONE - 1;  a1 = -8388608; end
        end
        frm.push_back(a1);
        frm.push_back(a2);
    endtask

    task automatic build_fixed(input int bad);
        frm.delete();
        for (int k = 0; k < NS; k++) begin
            frm.push_back(32'h100000);
            frm.push_back(32'h200000);
            frm.push_back(32'h100000);
            frm.push_back(32'hA00000);
            frm.push_back(k == bad ? 32'h400000 : 32'h240000);
        end
    endtask

    task automatic build_random(input int bad, input int bmode);
        frm.delete();
        for (int k = 0; k < NS; k++) add_sec(k == bad ? bmode : 0);
    endtask

    task automatic build_len(input int len);
        frm.delete();
        for (int i = 0; i < len; i++) frm.push_back(int'($urandom));
    endtask

    // Driver: called and returns at posedge+1; cfg_last marks the final queued word
    task automatic send_frame();
        int  w, tries;
        bit  rdy;
        for (int i = 0; i < frm.size(); i++) begin
            if ($urandom_range(0, 3) == 0) begin
                cfg_valid = 1'b0;
                cfg_data  = W'($urandom);
                @(posedge clk);
                #1;
            end
            w         = frm[i];
            cfg_valid = 1'b1;
            cfg_data  = w[W-1:0];
            cfg_last  = (i == frm.size() - 1);
            tries     = 0;
            do begin
                rdy = cfg_ready;
                @(posedge clk);
                if (rdy && cfg_last) t_last = $time;
                #1;
                tries++;
            end while (!rdy && tries < 1000);
            if (!rdy) chk("ready_timeout", 0, 1);
        end
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
    endtask

    task automatic drain();
        int c = 0;
        while (sb.size() != 0 && c < 500) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout pending=%0d required=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic run_frame();
        expect_frame();
        send_frame();
        drain();
    endtask

    // Monitor: pops an expectation for every event pulse and checks the active bank every cycle
    always @(negedge clk) begin
        exp_t e;
        int   got_kind;
        if (rst_n && (commit_done || err_len || err_unstable)) begin
            if (sb.size() == 0) begin
                chk("unexpected_event", {commit_done, err_len, err_unstable}, 0);
            end else begin
                e = sb.pop_front();
                got_kind = commit_done ? 0 : err_len ? 1 : 2;
                chk("event_kind", got_kind, e.kind);
                if (e.kind == 0 && got_kind == 0) begin
                    exp_act = e.bank;
                    exp_gen = (exp_gen + 1) % 256;
                    if (e.lat) chk("commit_latency", $time - P / 2, t_last + (NS + 1) * P);
                end
                if (e.kind == 2 && got_kind == 2) exp_sec = e.sec;
            end
        end
        chk("buses", {a2_bus, a1_bus, b2_bus, b1_bus, b0_bus}, exp_act);
        chk("cfg_gen", cfg_gen, exp_gen);
        chk("err_sec", err_sec, exp_sec);
    end

    initial begin
        int mode, bad;
        pass_bank = '0;
        for (int k = 0; k < NS; k++) pass_bank[0][k * W +: W] = W'(ONE);
        exp_act = pass_bank;
        repeat (3) @(posedge clk);
        #1;
        chk("ready_in_reset", cfg_ready, 0);
        rst_n = 1'b1;
        #1;
        chk("ready_after_release", cfg_ready, 1);
        @(posedge clk);
        #1;

        build_fixed(-1);
        run_frame();
        chk("gen_after_first", cfg_gen, 1);

        build_fixed(2);
        run_frame();

        build_len(7);
        run_frame();
        build_random(-1, 0);
        run_frame();

        build_len(N + 3);
        run_frame();
        build_fixed(-1);
        run_frame();

        filt_idle = 1'b0;
        lat_mode  = 1'b0;
        build_random(-1, 0);
        expect_frame();
        send_frame();
        repeat (50) begin
            @(posedge clk);
            #1;
            chk("wait_ready_low", cfg_ready, 0);
            chk("wait_no_commit", commit_done, 0);
        end
        filt_idle = 1'b1;
        drain();

        filt_idle = 1'b0;
        build_random(-1, 0);
        expect_frame();
        send_frame();
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        exp_act = pass_bank;
        exp_gen = 0;
        exp_sec = 0;
        #1;
        chk("async_reset_b0", b0_bus, pass_bank[0]);
        chk("async_reset_ready", cfg_ready, 0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        filt_idle = 1'b1;
        repeat (8) begin
            @(posedge clk);
            #1;
            chk("post_reset_no_commit", commit_done, 0);
        end
        lat_mode = 1'b1;

        for (int it = 0; it < 16; it++) begin
            mode = int'($urandom_range(0, 9));
            bad  = int'($urandom_range(0, NS - 1));
            if (mode < 5)       build_random(-1, 0);
            else if (mode == 5) build_random(bad, 1);
            else if (mode < 8)  build_random(bad, 2);
            else if (mode == 8) build_len(int'($urandom_range(1, N - 1)));
            else                build_len(int'($urandom_range(N + 1, N + 4)));
            run_frame();
        end

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
